axi4_lite_master_engine: RTL and testbench
==========================================

# axi4_lite_master_engine

Synthesizable AXI4-Lite master that turns single-word read/write commands into AXI4-Lite transactions and returns one response per command. It is the upstream stage that drives `axi4_lite_slave_bfm` (and real AXI4-Lite slaves) in bench and FPGA builds. It allows one outstanding transaction, 32-bit data only, and has a hung-slave timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles a bus-wait state may last before abort; 0 disables the timeout.
- AXCACHE, 4'h2: value driven on m_awcache/m_arcache.
- AXPROT, 3'b000: value driven on m_awprot/m_arprot.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- cmd_valid / cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address, passed through unmodified.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes, passed through unmodified.
- rsp_valid / rsp_ready  out/in  1/1  response handshake.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP; SLVERR on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- m_awaddr 32, m_awcache 4, m_awprot 3, m_awvalid 1 (out); m_awready 1 (in).
- m_wdata 32, m_wstrb 4, m_wvalid 1 (out); m_wready 1 (in).
- m_bresp 2, m_bvalid 1 (in); m_bready 1 (out).
- m_araddr 32, m_arcache 4, m_arprot 3, m_arvalid 1 (out); m_arready 1 (in).
- m_rdata 32, m_rresp 2, m_rvalid 1 (in); m_rready 1 (out).

## Operation
- All outputs are registered. Reset value of every output is 0, except m_awcache/m_arcache = AXCACHE and m_awprot/m_arprot = AXPROT.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, capture the command. A write goes to WR_REQ; a read goes to RD_REQ.
  - WR_REQ: m_awvalid=1, m_wvalid=1, m_bready=1.
    - Each valid drops the cycle after its own handshake. AW and W may complete in either order or together.
    - When both are done, go to WR_RESP.
    - If m_bvalid arrives while still in WR_REQ, it is accepted. This is legal only after both handshakes; bvalid earlier than that is ignored.
  - WR_RESP: m_bready=1. On m_bvalid, capture m_bresp and go to RSP.
  - RD_REQ: m_arvalid=1, m_rready=1.
    - m_arvalid drops after its handshake, then go to RD_DATA.
    - m_rvalid arriving in the same cycle as the AR handshake is accepted.
  - RD_DATA: m_rready=1. On m_rvalid, capture m_rdata/m_rresp and go to RSP.
  - RSP: rsp_valid=1, payload held stable. On rsp_ready, go to IDLE; rsp_valid=0 the next cycle.
- Address and data outputs hold the captured values from command accept until the next accept. They are never changed while a valid is high.
- Timeout: the counter clears on command accept and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA. When it reaches TIMEOUT_CYCLES:
  - all m_*valid and m_*ready go to 0;
  - rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0;
  - go to RSP.
  - This is a deliberate AXI deviation, used for hung-slave detection only.
- Reset mid-transaction: in the cycle after reset is sampled, everything returns to reset values and state goes to IDLE. No response is produced for the in-flight command.

## Timing
- Command accepted at edge N; m_awvalid/m_wvalid or m_arvalid are high from cycle N+1.
- Response accepted at edge M (bvalid&bready or rvalid&rready); rsp_valid is high from M+1.
- With a zero-wait slave:
  - write: cmd accept to rsp_valid = 3 cycles;
  - read: 3 cycles (ARREADY at N+1, RVALID at N+2).
- m_bready/m_rready are high throughout the transaction, as required by slaves that re-arm on bready/rready.
- Back-to-back commands: the next cmd_ready is the cycle after rsp handshake. Minimum 1 idle cycle between transactions.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entering the first wait state.

## Structure
- Package axi4_lite_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the master state enum;
  - a cmd struct {write, addr, wdata, wstrb}.
- One sub-module, axi_wait_timer: parameterised counter with clear, enable and expire output, reusable by other masters.

## Test plan
- Write 0x1000 / 0xDEADBEEF / wstrb 4'hF to zero-wait slave:
  - AW and W both seen at N+1, bready=1;
  - rsp_valid at N+3 with rsp_write=1, rsp_resp=00.
- Read 0x2000, slave returns 0x12345678 / RRESP 2'b10 after 5 wait cycles:
  - rsp_rdata=0x12345678, rsp_resp=10, rsp_timeout=0.
- Slave gives WREADY 4 cycles before AWREADY:
  - wvalid drops after its own handshake;
  - awvalid stays high until AWREADY;
  - exactly one write response.
- rsp_ready held low 10 cycles: rsp_valid and payload stable for all 10; cmd_ready=0 throughout.
- TIMEOUT_CYCLES=16, slave never raises ARREADY:
  - arvalid drops after 16 cycles;
  - rsp_resp=10, rsp_timeout=1;
  - next command is accepted normally.
- aresetn low for one cycle during WR_RESP:
  - all outputs reach reset values the next cycle;
  - no rsp_valid;
  - a subsequent read completes correctly.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master engine.
// Response codes, FSM states and command/response bundles.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RSP
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } rsp_t;

endpackage

// File: rtl/axi_wait_timer.sv
// Bus-wait watchdog: counts enabled cycles since clear.
// expire is high in the cycle whose edge brings the count to CYCLES.
module axi_wait_timer #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned LAST = (CYCLES > 0) ? CYCLES - 1 : 0;

  logic [W-1:0] cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
  end

  assign expire = (CYCLES != 0) && en &&
                  (cnt_q == LAST[W-1:0]);

endmodule

// File: rtl/axi4_lite_master_engine.sv
// Single-outstanding AXI4-Lite master with hung-slave timeout.
// One command in, one response out; all outputs registered.
module axi4_lite_master_engine
  import axi4_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [3:0]  AXCACHE = 4'h2,
  parameter logic [2:0]  AXPROT = 3'b000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awcache,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;
  logic   brdy_q, brdy_d, rrdy_q, rrdy_d;
  logic   crdy_q, crdy_d;
  logic   accept, wait_st, expire, done;
  logic [1:0]  done_resp;
  logic [31:0] done_rdata;

  assign accept = cmd_valid & crdy_q;
  assign wait_st = (state_q == S_WR_REQ) ||
                   (state_q == S_WR_RESP) ||
                   (state_q == S_RD_REQ) ||
                   (state_q == S_RD_DATA);

  axi_wait_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .aclk   (aclk),
    .aresetn(aresetn),
    .clr    (accept),
    .en     (wait_st),
    .expire (expire)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      brdy_q  <= 1'b0;
      rrdy_q  <= 1'b0;
      crdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      brdy_q  <= brdy_d;
      rrdy_q  <= rrdy_d;
      crdy_q  <= crdy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rsp_d      = rsp_q;
    awv_d      = awv_q;
    wv_d       = wv_q;
    arv_d      = arv_q;
    brdy_d     = brdy_q;
    rrdy_d     = rrdy_q;
    done       = 1'b0;
    done_resp  = RESP_OKAY;
    done_rdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d = '{write: cmd_write, addr: cmd_addr,
                    wdata: cmd_wdata, wstrb: cmd_wstrb};
          if (cmd_write) begin
            state_d = S_WR_REQ;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            brdy_d  = 1'b1;
          end else begin
            state_d = S_RD_REQ;
            arv_d   = 1'b1;
            rrdy_d  = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        awv_d = awv_q & ~m_awready;
        wv_d  = wv_q & ~m_wready;
        // B is honoured only once both address and data are taken
        if (!awv_d && !wv_d) begin
          state_d = S_WR_RESP;
          if (m_bvalid) begin
            done      = 1'b1;
            done_resp = m_bresp;
          end
        end
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          done      = 1'b1;
          done_resp = m_bresp;
        end
      end
      S_RD_REQ: begin
        arv_d = arv_q & ~m_arready;
        if (!arv_d) begin
          state_d = S_RD_DATA;
          if (m_rvalid) begin
            done       = 1'b1;
            done_resp  = m_rresp;
            done_rdata = m_rdata;
          end
        end
      end
      S_RD_DATA: begin
        if (m_rvalid) begin
          done       = 1'b1;
          done_resp  = m_rresp;
          done_rdata = m_rdata;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_d.valid = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // timeout overrides any completion seen on the same edge
    if (done || expire) begin
      state_d       = S_RSP;
      awv_d         = 1'b0;
      wv_d          = 1'b0;
      arv_d         = 1'b0;
      brdy_d        = 1'b0;
      rrdy_d        = 1'b0;
      rsp_d.valid   = 1'b1;
      rsp_d.write   = cmd_q.write;
      rsp_d.timeout = expire;
      rsp_d.resp    = expire ? RESP_SLVERR : done_resp;
      rsp_d.rdata   = (expire || cmd_q.write) ? '0 : done_rdata;
    end
  end

  always_comb crdy_d = (state_d == S_IDLE);

  assign cmd_ready   = crdy_q;
  assign rsp_valid   = rsp_q.valid;
  assign rsp_write   = rsp_q.write;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_resp    = rsp_q.resp;
  assign rsp_timeout = rsp_q.timeout;
  assign m_awaddr    = cmd_q.addr;
  assign m_awcache   = AXCACHE;
  assign m_awprot    = AXPROT;
  assign m_awvalid   = awv_q;
  assign m_wdata     = cmd_q.wdata;
  assign m_wstrb     = cmd_q.wstrb;
  assign m_wvalid    = wv_q;
  assign m_bready    = brdy_q;
  assign m_araddr    = cmd_q.addr;
  assign m_arcache   = AXCACHE;
  assign m_arprot    = AXPROT;
  assign m_arvalid   = arv_q;
  assign m_rready    = rrdy_q;

endmodule

// File: tb/tb_axi4_lite_master_engine.sv
// Bench for axi4_lite_master_engine: directed table, reset and
// random transactions against a latency/response reference model.
module tb_axi4_lite_master_engine;

  localparam int TMO = 16;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw;
    int          wd;
    int          b;
    int          ar;
    int          r;
    logic        hang;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    int          lat;
    logic [1:0]  eresp;
    logic [31:0] erdata;
    logic        eto;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_awcache, m_arcache, m_wstrb;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  int n_vec = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  axi4_lite_master_engine #(
    .TIMEOUT_CYCLES(TMO),
    .AXCACHE       (4'h2),
    .AXPROT        (3'b001)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_awaddr   (m_awaddr),
    .m_awcache  (m_awcache),
    .m_awprot   (m_awprot),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .m_araddr   (m_araddr),
    .m_arcache  (m_arcache),
    .m_arprot   (m_arprot),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready)
  );

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic w, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] wstrb, input int aw, input int wd, input int b,
    input int ar, input int r, input logic hang, input logic [1:0] resp,
    input logic [31:0] rdata, input int hold, input int lat,
    input logic [1:0] eresp, input logic [31:0] erdata, input logic eto);
    vec_t v;
    v.w = w; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.aw = aw; v.wd = wd; v.b = b; v.ar = ar; v.r = r;
    v.hang = hang; v.resp = resp; v.rdata = rdata; v.hold = hold;
    v.lat = lat; v.eresp = eresp; v.erdata = erdata; v.eto = eto;
    return v;
  endfunction

  // Reference: zero-wait costs 3 cycles, each slave stall adds one,
  // AW/W overlap, and a total past TMO wait cycles becomes an abort.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    int n;
    e = v;
    if (v.w) n = 3 + ((v.aw > v.wd) ? v.aw : v.wd) + v.b;
    else n = 3 + v.ar + v.r;
    if (v.hang || n > TMO) begin
      e.lat = TMO + 1; e.eresp = 2'b10; e.erdata = '0; e.eto = 1'b1;
    end else begin
      e.lat = n; e.eresp = v.resp; e.eto = 1'b0;
      e.erdata = v.w ? 32'h0 : v.rdata;
    end
    return e;
  endfunction

  task automatic slave_idle();
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic chk_reset();
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_flags", rsp_write | rsp_timeout, 1'b0);
    chk32("rst_rsp_data", rsp_rdata | 32'(rsp_resp), 32'h0);
    chk32("rst_addr", m_awaddr | m_araddr, 32'h0);
    chk32("rst_wdata", m_wdata | 32'(m_wstrb), 32'h0);
    chk1("rst_valids", m_awvalid | m_wvalid | m_arvalid, 1'b0);
    chk1("rst_readies", m_bready | m_rready, 1'b0);
    chk32("rst_cache", {m_awcache, m_arcache}, 32'h22);
    chk32("rst_prot", {m_awprot, m_arprot}, 32'h9);
  endtask

  task automatic run(input vec_t v, input int rst_at);
    logic aw_d, w_d, ar_d;
    int aw_n, w_n, ar_n, b_n, r_n, n_h, c;
    aw_d = 0; w_d = 0; ar_d = 0;
    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; n_h = 0;
    c = 0;
    while (!cmd_ready && c < 8) begin
      @(negedge aclk);
      c++;
    end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1; cmd_write = v.w; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    m_rdata = $urandom;
    @(negedge aclk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    c = 1;
    chk1("cmd_ready_busy", cmd_ready, 1'b0);
    while (!rsp_valid && c < 40) begin
      if (c == rst_at) begin
        aresetn = 0;
        slave_idle();
        @(negedge aclk);
        aresetn = 1;
        chk_reset();
        repeat (6) begin
          @(negedge aclk);
          chk1("no_rsp_after_rst", rsp_valid, 1'b0);
        end
        return;
      end
      if (m_awvalid) chk32("awaddr", m_awaddr, v.addr);
      if (m_wvalid) begin
        chk32("wdata", m_wdata, v.wdata);
        chk32("wstrb", 32'(m_wstrb), 32'(v.wstrb));
      end
      if (m_arvalid) chk32("araddr", m_araddr, v.addr);
      chk1("bready", m_bready, v.w);
      chk1("rready", m_rready, !v.w);
      if (v.w) begin
        chk1("awvalid", m_awvalid, !aw_d);
        chk1("wvalid", m_wvalid, !w_d);
        if (aw_d && w_d) begin
          if (b_n == v.b) begin
            m_bvalid = 1; m_bresp = v.resp;
          end else b_n++;
        end
        m_awready = 0;
        if (m_awvalid && !aw_d && !v.hang) begin
          if (aw_n == v.aw) begin m_awready = 1; aw_d = 1; end
          else aw_n++;
        end
        m_wready = 0;
        if (m_wvalid && !w_d) begin
          if (w_n == v.wd) begin m_wready = 1; w_d = 1; end
          else w_n++;
        end
        if (m_bvalid && m_bready) n_h++;
      end else begin
        chk1("arvalid", m_arvalid, !ar_d);
        if (ar_d) begin
          if (r_n == v.r) begin
            m_rvalid = 1; m_rresp = v.resp; m_rdata = v.rdata;
          end else r_n++;
        end
        m_arready = 0;
        if (m_arvalid && !ar_d && !v.hang) begin
          if (ar_n == v.ar) begin m_arready = 1; ar_d = 1; end
          else ar_n++;
        end
        if (m_rvalid && m_rready) n_h++;
      end
      @(negedge aclk);
      c++;
    end
    slave_idle();
    chk1("rsp_bound", rsp_valid, 1'b1);
    chk32("latency", c, v.lat);
    if (!v.eto) chk32("slave_handshakes", n_h, 1);
    for (int i = 0; i <= v.hold; i++) begin
      if (i > 0) @(negedge aclk);
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk1("rsp_write", rsp_write, v.w);
      chk32("rsp_rdata", rsp_rdata, v.erdata);
      chk32("rsp_resp", 32'(rsp_resp), 32'(v.eresp));
      chk1("rsp_timeout", rsp_timeout, v.eto);
      chk1("cmd_ready_rsp", cmd_ready, 1'b0);
      chk1("bus_quiet", m_awvalid | m_wvalid | m_arvalid |
                        m_bready | m_rready, 1'b0);
    end
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    chk1("rsp_drop", rsp_valid, 1'b0);
    chk1("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  vec_t tbl [9];

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0;
    slave_idle();
    //        w   addr      wdata         st aw wd b ar r hg rsp  rdata  hold lat er  erdata  to
    tbl[0] = mk(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00,
                32'h0, 0, 3, 2'b00, 32'h0, 0);
    tbl[1] = mk(0, 32'h2000, 32'h0, 4'h0, 0, 0, 0, 0, 5, 0, 2'b10,
                32'h12345678, 0, 8, 2'b10, 32'h12345678, 0);
    tbl[2] = mk(1, 32'h3004, 32'hCAFEF00D, 4'h3, 4, 0, 0, 0, 0, 0, 2'b00,
                32'h0, 0, 7, 2'b00, 32'h0, 0);
    tbl[3] = mk(0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00,
                32'hA5A55A5A, 10, 3, 2'b00, 32'hA5A55A5A, 0);
    tbl[4] = mk(0, 32'h2000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'b00,
                32'h77, 0, 17, 2'b10, 32'h0, 1);
    tbl[5] = mk(0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b01,
                32'h11223344, 0, 3, 2'b01, 32'h11223344, 0);
    tbl[6] = mk(1, 32'h50, 32'h01020304, 4'h8, 0, 1, 2, 0, 0, 0, 2'b11,
                32'h0, 2, 6, 2'b11, 32'h0, 0);
    tbl[7] = mk(1, 32'h60, 32'h55AA55AA, 4'hF, 0, 0, 0, 0, 0, 1, 2'b00,
                32'h0, 0, 17, 2'b10, 32'h0, 1);
    tbl[8] = mk(1, 32'h64, 32'h0BADF00D, 4'h1, 0, 3, 0, 0, 0, 0, 2'b00,
                32'h0, 1, 6, 2'b00, 32'h0, 0);
    repeat (3) @(negedge aclk);
    chk_reset();
    aresetn = 1;
    @(negedge aclk);
    chk1("cmd_ready_init", cmd_ready, 1'b1);
    for (int i = 0; i < 9; i++) run(tbl[i], 0);
    // reset while the write waits in WR_RESP, then a clean read
    run(mk(1, 32'h80, 32'h12121212, 4'hF, 0, 0, 3, 0, 0, 0, 2'b00,
           32'h0, 0, 6, 2'b00, 32'h0, 0), 3);
    run(mk(0, 32'h84, 32'h0, 4'h0, 1, 0, 0, 1, 1, 0, 2'b00,
           32'h9ABCDEF0, 0, 5, 2'b00, 32'h9ABCDEF0, 0), 0);
    for (int k = 0; k < 40; k++) begin
      vec_t v;
      v = '0;
      v.w = 1'($urandom);
      v.addr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.wstrb = 4'($urandom);
      v.aw = $urandom_range(0, 9);
      v.wd = $urandom_range(0, 9);
      v.b = $urandom_range(0, 9);
      v.ar = $urandom_range(0, 9);
      v.r = $urandom_range(0, 9);
      v.hang = ($urandom_range(0, 15) == 0);
      v.resp = 2'($urandom);
      v.rdata = $urandom;
      v.hold = $urandom_range(0, 3);
      run(model(v), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
